// File: rtl/ps2_kbd_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ps2_kbd_if : PS/2 line inputs and decoded key-event outputs               |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
interface ps2_kbd_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [8:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_pressed;
  logic       frame_err;
  logic [7:0] err_cnt;

  modport master (
    output ps2_clk, ps2_data,
    input  key_code, key_valid, key_release, key_pressed, frame_err, err_cnt
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key_code, key_valid, key_release, key_pressed, frame_err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ps2_kbd_rx : PS/2 keyboard frame receiver and E0/F0 scan-code decoder     |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
module ps2_kbd_rx #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 3
) (
  input  logic        clk,
  input  logic        rst,
  ps2_kbd_if.slave    bus_if
);

  localparam int         C_TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [C_TW-1:0] C_TO_LAST = C_TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXT  = 2'd1,
    ST_BRK  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [3:0]             bit_cnt_q;
  logic [9:0]             shift_q;
  logic [C_TW-1:0]        to_cnt_q;
  logic [7:0]             byte_q;
  logic                   byte_vld_q;
  logic                   frame_err_q;
  logic [7:0]             err_cnt_q;

  state_t                 state_q;
  logic                   ext_q;
  logic [8:0]             key_code_q;
  logic                   key_valid_q;
  logic                   key_release_q;
  logic                   key_pressed_q;

  logic w_fall;
  logic w_data;
  logic w_last;
  logic w_frame_ok;
  logic w_timeout;
  logic w_err;

  // Index 0 is the newest sample; the oldest two stages form the edge detector.
  assign w_fall     = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
  assign w_data     = data_sync_q[SYNC_STAGES-2];
  assign w_last     = w_fall && (bit_cnt_q == 4'd10);
  assign w_frame_ok = ~shift_q[0] & w_data & (^shift_q[9:1]);
  assign w_timeout  = !w_fall && (bit_cnt_q != 4'd0) && (to_cnt_q == C_TO_LAST);
  assign w_err      = (w_last & ~w_frame_ok) | w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus_if.ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus_if.ps2_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      byte_q      <= 8'h00;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= w_err;
      if (w_err && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
      if (w_fall) begin
        to_cnt_q <= '0;
        if (w_last) begin
          bit_cnt_q <= 4'd0;
          if (w_frame_ok) begin
            byte_q     <= shift_q[8:1];
            byte_vld_q <= 1'b1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          shift_q   <= {w_data, shift_q[9:1]};
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (w_timeout) begin
          bit_cnt_q <= 4'd0;
          to_cnt_q  <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end
    end
  end

  // Bad frames never raise byte_vld_q, so any pending prefix survives them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ext_q         <= 1'b0;
      key_code_q    <= 9'h000;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      if (byte_vld_q) begin
        case (state_q)
          ST_IDLE: begin
            if (byte_q == 8'hE0) begin
              state_q <= ST_EXT;
            end else if (byte_q == 8'hF0) begin
              state_q <= ST_BRK;
              ext_q   <= 1'b0;
            end else begin
              key_code_q    <= {1'b0, byte_q};
              key_valid_q   <= 1'b1;
              key_pressed_q <= 1'b1;
            end
          end
          ST_EXT: begin
            if (byte_q == 8'hF0) begin
              state_q <= ST_BRK;
              ext_q   <= 1'b1;
            end else if (byte_q != 8'hE0) begin
              key_code_q    <= {1'b1, byte_q};
              key_valid_q   <= 1'b1;
              key_pressed_q <= 1'b1;
              state_q       <= ST_IDLE;
            end
          end
          ST_BRK: begin
            key_code_q    <= {ext_q, byte_q};
            key_release_q <= 1'b1;
            if ({ext_q, byte_q} == key_code_q) begin
              key_pressed_q <= 1'b0;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus_if.key_code    = key_code_q;
  assign bus_if.key_valid   = key_valid_q;
  assign bus_if.key_release = key_release_q;
  assign bus_if.key_pressed = key_pressed_q;
  assign bus_if.frame_err   = frame_err_q;
  assign bus_if.err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_ps2_kbd_rx : directed frame vectors and corner sequences for ps2_kbd_rx|
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
module tb_ps2_kbd_rx;

  localparam int C_TIMEOUT = 100;

  typedef struct {
    logic [7:0] b;
    bit         bad;
    int         nv;
    int         nr;
    int         ne;
    logic [8:0] code;
    bit         pr;
    int         ec;
  } vec_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  vec_t vecs[15];

  ps2_kbd_if ifc ();

  ps2_kbd_rx #(
    .TIMEOUT_CYC (C_TIMEOUT),
    .SYNC_STAGES (3)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ifc.ps2_data = b;
    repeat (2) @(negedge clk);
    ifc.ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    ifc.ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Sends a whole frame and watches the pulses following the final falling edge.
  task automatic send_frame(input logic [7:0] b, input bit bad,
                            output int nv, output int nr, output int ne,
                            output int pk, output int pe);
    logic [10:0] f;
    f  = {1'b1, (~^b) ^ bad, b, 1'b0};
    nv = 0; nr = 0; ne = 0; pk = 0; pe = 0;
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    @(negedge clk);
    ifc.ps2_data = f[10];
    repeat (2) @(negedge clk);
    ifc.ps2_clk = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ifc.key_valid)   begin nv++; pk = k; end
      if (ifc.key_release) begin nr++; pk = k; end
      if (ifc.frame_err)   begin ne++; pe = k; end
      if (k == 4) ifc.ps2_clk = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int nv, nr, ne, pk, pe;
    string t;
    send_frame(v.b, v.bad, nv, nr, ne, pk, pe);
    t = $sformatf("v%0d_%02h", idx, v.b);
    chk({t, "_valid"},   nv, v.nv);
    chk({t, "_release"}, nr, v.nr);
    chk({t, "_err"},     ne, v.ne);
    chk({t, "_code"},    int'(ifc.key_code), int'(v.code));
    chk({t, "_pressed"}, int'(ifc.key_pressed), int'(v.pr));
    chk({t, "_errcnt"},  int'(ifc.err_cnt), v.ec);
    if (v.nv + v.nr > 0) chk({t, "_latency"}, pk, 4);
    if (v.ne > 0)        chk({t, "_errlat"},  pe, 3);
  endtask

  initial begin
    int nv, nr, ne, pk, pe;
    logic [10:0] fr;
    n_pass = 0;
    n_total = 0;
    ifc.ps2_clk  = 1'b1;
    ifc.ps2_data = 1'b1;
    rst = 1'b1;

    // {byte, bad parity, #valid, #release, #err, code, pressed, err_cnt}
    vecs[0]  = '{8'h1C, 1'b0, 1, 0, 0, 9'h01C, 1'b1, 0};
    vecs[1]  = '{8'hF0, 1'b0, 0, 0, 0, 9'h01C, 1'b1, 0};
    vecs[2]  = '{8'h1C, 1'b0, 0, 1, 0, 9'h01C, 1'b0, 0};
    vecs[3]  = '{8'hE0, 1'b0, 0, 0, 0, 9'h01C, 1'b0, 0};
    vecs[4]  = '{8'h75, 1'b0, 1, 0, 0, 9'h175, 1'b1, 0};
    vecs[5]  = '{8'hE0, 1'b0, 0, 0, 0, 9'h175, 1'b1, 0};
    vecs[6]  = '{8'hF0, 1'b0, 0, 0, 0, 9'h175, 1'b1, 0};
    vecs[7]  = '{8'h75, 1'b0, 0, 1, 0, 9'h175, 1'b0, 0};
    vecs[8]  = '{8'h1C, 1'b1, 0, 0, 1, 9'h175, 1'b0, 1};
    vecs[9]  = '{8'h32, 1'b0, 1, 0, 0, 9'h032, 1'b1, 1};
    vecs[10] = '{8'hE0, 1'b0, 0, 0, 0, 9'h032, 1'b1, 1};
    vecs[11] = '{8'h12, 1'b1, 0, 0, 1, 9'h032, 1'b1, 2};
    vecs[12] = '{8'h12, 1'b0, 1, 0, 0, 9'h112, 1'b1, 2};
    vecs[13] = '{8'hF0, 1'b0, 0, 0, 0, 9'h112, 1'b1, 2};
    vecs[14] = '{8'h1C, 1'b0, 0, 1, 0, 9'h01C, 1'b1, 2};

    repeat (2) @(negedge clk);
    chk("rst_code",    int'(ifc.key_code), 0);
    chk("rst_pressed", int'(ifc.key_pressed), 0);
    chk("rst_errcnt",  int'(ifc.err_cnt), 0);
    chk("rst_pulses",  int'({ifc.key_valid, ifc.key_release, ifc.frame_err}), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Timeout: five bits then a silent bus.
    fr = {1'b1, ~^8'h45, 8'h45, 1'b0};
    for (int i = 0; i < 5; i++) send_bit(fr[i]);
    nv = 0; ne = 0;
    for (int k = 0; k < C_TIMEOUT + 10; k++) begin
      @(negedge clk);
      if (ifc.frame_err) ne++;
      if (ifc.key_valid || ifc.key_release) nv++;
    end
    chk("to_err",    ne, 1);
    chk("to_nokey",  nv, 0);
    chk("to_errcnt", int'(ifc.err_cnt), 3);
    run_vec('{8'h45, 1'b0, 1, 0, 0, 9'h045, 1'b1, 3}, 15);

    // Reset in the middle of a frame that follows a break prefix.
    run_vec('{8'hF0, 1'b0, 0, 0, 0, 9'h045, 1'b1, 3}, 16);
    fr = {1'b1, ~^8'h16, 8'h16, 1'b0};
    for (int i = 0; i < 6; i++) send_bit(fr[i]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_code",    int'(ifc.key_code), 0);
    chk("arst_pressed", int'(ifc.key_pressed), 0);
    chk("arst_errcnt",  int'(ifc.err_cnt), 0);
    chk("arst_pulses",  int'({ifc.key_valid, ifc.key_release, ifc.frame_err}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_vec('{8'h16, 1'b0, 1, 0, 0, 9'h016, 1'b1, 0}, 17);

    // Saturation of the error counter.
    for (int i = 0; i < 255; i++) send_frame(8'h00, 1'b1, nv, nr, ne, pk, pe);
    chk("sat_255", int'(ifc.err_cnt), 8'hFF);
    send_frame(8'h00, 1'b1, nv, nr, ne, pk, pe);
    chk("sat_hold",     int'(ifc.err_cnt), 8'hFF);
    chk("sat_err_puls", ne, 1);
    chk("sat_code",     int'(ifc.key_code), 9'h016);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
